// File: rtl/two_phase_clkgen_if.sv
// Control/status bundle for two_phase_clkgen; the stretch wait-state input
// exists only when CLKGEN_STRETCH_EN is defined.
interface two_phase_clkgen_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
`ifdef CLKGEN_STRETCH_EN
  logic             stretch;
`endif
  logic             c1;
  logic             c2;
  logic             busy;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_cnt;

`ifdef CLKGEN_STRETCH_EN
  modport master (output run, step, stretch, input c1, c2, busy, cycle_done, cycle_cnt);
  modport slave  (input run, step, stretch, output c1, c2, busy, cycle_done, cycle_cnt);
`else
  modport master (output run, step, input c1, c2, busy, cycle_done, cycle_cnt);
  modport slave  (input run, step, output c1, c2, busy, cycle_done, cycle_cnt);
`endif
endinterface

// File: rtl/two_phase_clkgen.sv
// Non-overlapping two-phase clock generator with free-run/step/halt control.
// Optional CLKGEN_STRETCH_EN adds a PH2 stretch (memory wait) input.
module two_phase_clkgen #(
  parameter int PH1_W = 2,
  parameter int PH2_W = 2,
  parameter int GAP_W = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  two_phase_clkgen_if.slave   bus
);

  // state | meaning
  // IDLE  | no machine cycle, both phases low
  // PH1   | c1 high
  // GAP1  | dead time between c1 and c2
  // PH2   | c2 high (may be stretched)
  // GAP2  | dead time closing the machine cycle
  typedef enum logic [2:0] {IDLE, PH1, GAP1, PH2, GAP2} state_e;

  localparam int MAXW_A = (PH1_W > PH2_W) ? PH1_W : PH2_W;
  localparam int MAXW   = (MAXW_A > GAP_W) ? MAXW_A : GAP_W;
  localparam int PC_W   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [PC_W-1:0] LD_PH1 = PC_W'(PH1_W - 1);
  localparam logic [PC_W-1:0] LD_PH2 = PC_W'(PH2_W - 1);
  localparam logic [PC_W-1:0] LD_GAP = PC_W'(GAP_W - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic              step_q;
  logic              c1_q, c2_q, busy_q, done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              step_rise;
  logic              hold;
  logic              last;

  assign step_rise = bus.step & ~step_q;

`ifdef CLKGEN_STRETCH_EN
  assign hold = (state_q == PH2) && bus.stretch;
`else
  assign hold = 1'b0;
`endif

  // Terminal count of the per-state down-counter; a held PH2 never terminates.
  assign last = (ph_cnt_q == '0) && !hold;

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.run || step_rise) begin
          state_d  = PH1;
          ph_cnt_d = LD_PH1;
        end
      end
      PH1: begin
        if (last) begin
          state_d  = GAP1;
          ph_cnt_d = LD_GAP;
        end else begin
          ph_cnt_d = ph_cnt_q - PC_W'(1);
        end
      end
      GAP1: begin
        if (last) begin
          state_d  = PH2;
          ph_cnt_d = LD_PH2;
        end else begin
          ph_cnt_d = ph_cnt_q - PC_W'(1);
        end
      end
      PH2: begin
        if (last) begin
          state_d  = GAP2;
          ph_cnt_d = LD_GAP;
        end else if (!hold) begin
          ph_cnt_d = ph_cnt_q - PC_W'(1);
        end
      end
      GAP2: begin
        if (last) begin
          if (bus.run) begin
            state_d  = PH1;
            ph_cnt_d = LD_PH1;
          end else begin
            state_d  = IDLE;
            ph_cnt_d = '0;
          end
        end else begin
          ph_cnt_d = ph_cnt_q - PC_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        ph_cnt_d = '0;
      end
    endcase
  end

  // Outputs decode the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_cnt_q <= '0;
      step_q   <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      step_q   <= bus.step;
      c1_q     <= (state_d == PH1);
      c2_q     <= (state_d == PH2);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == GAP2) && (ph_cnt_d == '0);
      if ((state_q == GAP2) && last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.c1         = c1_q;
  assign bus.c2         = c2_q;
  assign bus.busy       = busy_q;
  assign bus.cycle_done = done_q;
  assign bus.cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_two_phase_clkgen.sv
// Scoreboard bench for two_phase_clkgen: a 16-bit counter instance and a
// 2-bit counter instance share stimulus; the monitor checks every cycle.
module tb_two_phase_clkgen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  two_phase_clkgen_if #(.CNT_W(16)) bif ();
  two_phase_clkgen_if #(.CNT_W(2))  wif ();

  two_phase_clkgen #(.PH1_W(2), .PH2_W(2), .GAP_W(1), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  two_phase_clkgen #(.PH1_W(2), .PH2_W(2), .GAP_W(1), .CNT_W(2)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wif.slave)
  );

  typedef struct {
    logic [3:0] ph;   // {c1, c2, busy, cycle_done}
    int         cnt;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   ecnt   = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {bif.c1, bif.c2, bif.busy, bif.cycle_done};
      total++;
      if (got === e.ph) passed++;
      else $display("FAIL %s phases {c1,c2,busy,done}: got %b want %b t=%0t", e.nm, got, e.ph, $time);
      total++;
      if (bif.cycle_cnt === 16'(e.cnt)) passed++;
      else $display("FAIL %s cycle_cnt: got %0d want %0d t=%0t", e.nm, bif.cycle_cnt, 16'(e.cnt), $time);
      total++;
      if (wif.cycle_cnt === 2'(e.cnt)) passed++;
      else $display("FAIL %s cycle_cnt_w2: got %0d want %0d t=%0t", e.nm, wif.cycle_cnt, 2'(e.cnt), $time);
    end
  end

  task automatic cyc(input logic r, input logic ru, input logic sp,
                     input logic [3:0] e, input string nm);
    exp_t x;
    rst = r;
    bif.run = ru;  wif.run = ru;
    bif.step = sp; wif.step = sp;
    @(posedge clk);
    if (r) ecnt = 0;
    else if (prev_done) ecnt++;
    prev_done = r ? 1'b0 : e[0];
    x.ph = e; x.cnt = ecnt; x.nm = nm;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // One full machine cycle; rv/sv give run/step per cycle, MSB first.
  task automatic run_cycle(input logic [5:0] rv, input logic [5:0] sv, input string nm);
    logic [5:0] p1, p2, pd;
    p1 = 6'b110000;
    p2 = 6'b000110;
    pd = 6'b000001;
    for (int i = 0; i < 6; i++)
      cyc(1'b0, rv[5-i], sv[5-i], {p1[5-i], p2[5-i], 1'b1, pd[5-i]}, nm);
  endtask

  task automatic idle_cyc(input logic ru, input logic sp, input string nm);
    cyc(1'b0, ru, sp, 4'b0000, nm);
  endtask

  initial begin
    rst = 1'b1;
    bif.run = 1'b1; wif.run = 1'b1;
    bif.step = 1'b0; wif.step = 1'b0;
`ifdef CLKGEN_STRETCH_EN
    bif.stretch = 1'b0; wif.stretch = 1'b0;
`endif
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000, "reset");

    for (int p = 0; p < 5; p++) run_cycle(6'b111111, 6'b000000, "freerun");
    idle_cyc(1'b0, 1'b0, "freerun_stop");
    idle_cyc(1'b0, 1'b0, "idle");

    run_cycle(6'b000000, 6'b100000, "single_step");
    idle_cyc(1'b0, 1'b0, "single_step_end");
    idle_cyc(1'b0, 1'b0, "idle");

    run_cycle(6'b111111, 6'b000000, "halt_pre");
    run_cycle(6'b111100, 6'b000000, "halt_mid_ph2");
    idle_cyc(1'b0, 1'b0, "halt_end");

    run_cycle(6'b000000, 6'b111111, "step_held");
    for (int i = 0; i < 4; i++) idle_cyc(1'b0, 1'b1, "step_held_idle");
    idle_cyc(1'b0, 1'b0, "step_release");
    run_cycle(6'b000000, 6'b101010, "step_busy");
    idle_cyc(1'b0, 1'b0, "step_busy_end");

    run_cycle(6'b111111, 6'b100000, "run_and_step");
    run_cycle(6'b100000, 6'b000000, "run_and_step2");
    idle_cyc(1'b0, 1'b0, "run_and_step_end");

    cyc(1'b0, 1'b1, 1'b0, 4'b1010, "rst_mid");
    cyc(1'b0, 1'b1, 1'b0, 4'b1010, "rst_mid");
    cyc(1'b0, 1'b1, 1'b0, 4'b0010, "rst_mid");
    cyc(1'b0, 1'b1, 1'b0, 4'b0110, "rst_mid");
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, "rst_mid_ph2");
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, "rst_mid_hold");
    idle_cyc(1'b0, 1'b0, "post_rst");
    run_cycle(6'b100000, 6'b000000, "post_rst_run");
    idle_cyc(1'b0, 1'b0, "post_rst_end");

`ifdef CLKGEN_STRETCH_EN
    cyc(1'b0, 1'b0, 1'b1, 4'b1010, "stretch");
    cyc(1'b0, 1'b0, 1'b0, 4'b1010, "stretch");
    cyc(1'b0, 1'b0, 1'b0, 4'b0010, "stretch");
    cyc(1'b0, 1'b0, 1'b0, 4'b0110, "stretch");
    bif.stretch = 1'b1; wif.stretch = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'b0110, "stretch_hold");
    bif.stretch = 1'b0; wif.stretch = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 4'b0110, "stretch");
    cyc(1'b0, 1'b0, 1'b0, 4'b0011, "stretch");
    idle_cyc(1'b0, 1'b0, "stretch_end");
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/two_phase_clkgen.md
Name: two_phase_clkgen

Overview:
- Generates the two non-overlapping phase signals c1 and c2 from a single master clock.
- These feed the downstream clock-control stage, which samples c1 on each falling edge of c2.
- Provides free-run, single-step and graceful-halt control so the lab datapath can be clocked continuously or one machine cycle at a time.
- Reports machine-cycle completion and keeps a running count of completed cycles.

Parameters:
- PH1_W, 2, c1 high time in clk cycles (>=1)
- PH2_W, 2, c2 high time in clk cycles (>=1)
- GAP_W, 1, dead time between phases in clk cycles (>=1); guarantees non-overlap
- CNT_W, 16, width of the completed-cycle counter

Ports:
- clk  input  1  master clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  level; 1 = free-run machine cycles
- step  input  1  single-step request; rising edge detected internally
- c1  output  1  phase 1, registered
- c2  output  1  phase 2, registered
- busy  output  1  1 while a machine cycle is in progress (state != IDLE)
- cycle_done  output  1  one-clk pulse in the last cycle of GAP2
- cycle_cnt  output  CNT_W  completed machine cycles, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high.
- Reset: state=IDLE, phase counter=0, step edge register=0, c1=0, c2=0, busy=0, cycle_done=0, cycle_cnt=0. rst overrides all other inputs, including mid-phase; c1 and c2 are 0 in the cycle after rst is sampled.
- FSM states: IDLE, PH1, GAP1, PH2, GAP2. A per-state down-counter is loaded with the state width minus 1 on entry.
  - IDLE -> PH1 when run=1 or a step rising edge is seen (step=1, previous step=0).
  - PH1 -> GAP1 after PH1_W cycles.
  - GAP1 -> PH2 after GAP_W cycles.
  - PH2 -> GAP2 after PH2_W cycles.
  - GAP2 -> PH1 after GAP_W cycles if run=1 at the final GAP2 cycle; otherwise GAP2 -> IDLE.
- Outputs are decoded from the registered state: c1=1 exactly in PH1, c2=1 exactly in PH2. Both are never 1 in the same cycle, and at least GAP_W zero cycles separate them on both sides.
- Latency: the start condition is sampled at edge k; c1 rises at edge k (the first PH1 cycle follows it).
- Machine-cycle period = PH1_W + PH2_W + 2*GAP_W clk cycles. Back-to-back cycles under run have no extra idle cycle.
- cycle_done is asserted in the final GAP2 cycle. cycle_cnt increments on the same edge that leaves GAP2 and wraps from all-ones to 0.
- Halt: deasserting run never truncates a phase. The current machine cycle completes through GAP2, then the FSM returns to IDLE.
- A step edge while busy is ignored; it is not queued.
- run=1 and a step edge together in IDLE start exactly one transition to PH1. Free-run then continues because run=1.
- step held high produces only one machine cycle; step must return to 0 before the next edge counts.

Optional Feature:
- Macro: CLKGEN_STRETCH_EN.
- Defined: an extra input port stretch (1 bit) is present. While in PH2 with stretch=1, the phase counter holds, so c2 stays high (memory wait state). PH2 ends only after PH2_W counted cycles with stretch=0. stretch is ignored in every other state.
- Undefined: the stretch port is absent, and PH2 always lasts exactly PH2_W cycles.

Test Plan (defaults, period 6):
- Reset: hold rst for 3 cycles with run=1 -> c1=c2=busy=cycle_done=0 and cycle_cnt=0 throughout; c1 rises on the first edge after rst drops.
- Single step: pulse step for 1 cycle -> c1 high 2 cycles, 1 low, c2 high 2 cycles, 1 low with cycle_done=1; cycle_cnt=1; busy=0 afterward.
- Free run: run=1 for 30 cycles -> 5 complete periods of pattern c1:110000, c2:000110; cycle_cnt=5; no c1/c2 overlap at any cycle.
- Halt mid-phase: drop run during the second cycle of PH2 -> remaining PH2 and GAP2 complete, then IDLE; the cycle is counted.
- Ignored step: hold step high 10 cycles, and also pulse step while busy -> only one machine cycle; cycle_cnt increments by 1.
- Wrap and stretch: with CNT_W=2, run 4 cycles -> cycle_cnt returns to 0. With CLKGEN_STRETCH_EN, stretch=1 for 3 cycles in PH2 -> c2 high 5 cycles total.
